// File: rtl/riscv_defs.sv
// Shared fetch-stage definitions: default PC geometry, next-PC select codes and PC FSM states.
package riscv_defs;

    localparam int          DEF_XLEN         = 64;
    localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h100;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_MRET,
        SEL_JALR,
        SEL_BR,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_e;

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } pc_state_e;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC arbitration: picks the highest-priority redirect source and flags misaligned targets.
module next_pc_select
    import riscv_defs::*;
#(
    parameter int          XLEN       = DEF_XLEN,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic            stall_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            jalr_taken_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic [XLEN-1:0] branch_target_i,
    output pc_sel_e         sel_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    always_comb begin
        sel_o    = SEL_SEQ;
        target_o = '0;
        if (trap_i) begin
            sel_o = SEL_TRAP;
        end else if (mret_i) begin
            sel_o    = SEL_MRET;
            target_o = epc_i;
        end else if (jalr_taken_i) begin
            sel_o    = SEL_JALR;
            target_o = {jalr_target_i[XLEN-1:1], 1'b0};
        end else if (branch_taken_i) begin
            sel_o    = SEL_BR;
            target_o = branch_target_i;
        end else if (stall_i) begin
            sel_o = SEL_HOLD;
        end
    end

    // Only target-carrying redirects can be misaligned; trap goes to a fixed vector.
    assign misaligned_o = (sel_o == SEL_MRET || sel_o == SEL_JALR || sel_o == SEL_BR) &&
                          ((target_o & ALIGN_MASK) != '0);

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage PC register with BOOT/RUN gating, prioritised redirects and misaligned-target trapping.
module program_counter_unit
    import riscv_defs::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jalr_taken,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap,
    input  logic            mret,
    input  logic [XLEN-1:0] epc_in,
    output logic [XLEN-1:0] PC_Out,
    output logic [XLEN-1:0] PC_Plus_Inc,
    output logic [XLEN-1:0] PC_Prev,
    output logic            fetch_valid,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_prev_q, pc_prev_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            misaligned_q, misaligned_d;

    pc_sel_e         sel;
    logic [XLEN-1:0] sel_target;
    logic            sel_misaligned;

    next_pc_select #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_pc_select (
        .stall_i         (stall),
        .trap_i          (trap),
        .mret_i          (mret),
        .jalr_taken_i    (jalr_taken),
        .branch_taken_i  (branch_taken),
        .epc_i           (epc_in),
        .jalr_target_i   (jalr_target),
        .branch_target_i (branch_target),
        .sel_o           (sel),
        .target_o        (sel_target),
        .misaligned_o    (sel_misaligned)
    );

    assign PC_Plus_Inc = pc_q + XLEN'(INC);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_prev_d    = pc_prev_q;
        bad_addr_d   = bad_addr_q;
        misaligned_d = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                case (sel)
                    SEL_TRAP: pc_d = TRAP_VECTOR;
                    SEL_MRET, SEL_JALR, SEL_BR: begin
                        if (sel_misaligned) begin
                            pc_d         = TRAP_VECTOR;
                            bad_addr_d   = sel_target;
                            misaligned_d = 1'b1;
                        end else begin
                            pc_d = sel_target;
                        end
                    end
                    SEL_HOLD: pc_d = pc_q;
                    default:  pc_d = PC_Plus_Inc;
                endcase
                // PC_Prev only tracks edges that actually move the PC, so it holds across stalls.
                if (pc_d != pc_q) pc_prev_d = pc_q;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            pc_prev_q    <= RESET_VECTOR;
            bad_addr_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_prev_q    <= pc_prev_d;
            bad_addr_q   <= bad_addr_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign PC_Out      = pc_q;
    assign PC_Prev     = pc_prev_q;
    assign bad_addr    = bad_addr_q;
    assign misaligned  = misaligned_q;
    assign fetch_valid = (state_q == ST_RUN) & ~stall;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit across four parameterisations, each exercised in turn.
module tb_program_counter_unit;

    logic        clock = 1'b0;
    logic        rst_a, rst_b, rst_c, rst_d;
    logic        stall, branch_taken, jalr_taken, trap, mret;
    logic [63:0] branch_target, jalr_target, epc_in;

    logic [63:0] pc_a, inc_a, prev_a, bad_a;
    logic        fv_a, mis_a;
    logic [63:0] pc_b, inc_b, prev_b, bad_b;
    logic        fv_b, mis_b;
    logic [31:0] pc_c, inc_c, prev_c, bad_c;
    logic        fv_c, mis_c;
    logic [31:0] pc_d, inc_d, prev_d, bad_d;
    logic        fv_d, mis_d;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    program_counter_unit u_a (
        .clock(clock), .reset(rst_a), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jalr_taken(jalr_taken), .jalr_target(jalr_target),
        .trap(trap), .mret(mret), .epc_in(epc_in),
        .PC_Out(pc_a), .PC_Plus_Inc(inc_a), .PC_Prev(prev_a),
        .fetch_valid(fv_a), .misaligned(mis_a), .bad_addr(bad_a)
    );

    program_counter_unit #(.ALIGN_BITS(1)) u_b (
        .clock(clock), .reset(rst_b), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jalr_taken(jalr_taken), .jalr_target(jalr_target),
        .trap(trap), .mret(mret), .epc_in(epc_in),
        .PC_Out(pc_b), .PC_Plus_Inc(inc_b), .PC_Prev(prev_b),
        .fetch_valid(fv_b), .misaligned(mis_b), .bad_addr(bad_b)
    );

    program_counter_unit #(.XLEN(32)) u_c (
        .clock(clock), .reset(rst_c), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target[31:0]),
        .jalr_taken(jalr_taken), .jalr_target(jalr_target[31:0]),
        .trap(trap), .mret(mret), .epc_in(epc_in[31:0]),
        .PC_Out(pc_c), .PC_Plus_Inc(inc_c), .PC_Prev(prev_c),
        .fetch_valid(fv_c), .misaligned(mis_c), .bad_addr(bad_c)
    );

    program_counter_unit #(.XLEN(32), .INC(2), .RESET_VECTOR(32'h1000)) u_d (
        .clock(clock), .reset(rst_d), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target[31:0]),
        .jalr_taken(jalr_taken), .jalr_target(jalr_target[31:0]),
        .trap(trap), .mret(mret), .epc_in(epc_in[31:0]),
        .PC_Out(pc_d), .PC_Plus_Inc(inc_d), .PC_Prev(prev_d),
        .fetch_valid(fv_d), .misaligned(mis_d), .bad_addr(bad_d)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jalr_taken = 0; trap = 0; mret = 0;
        branch_target = '0; jalr_target = '0; epc_in = '0;
    endtask

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
        clear_inputs();
        step();
        step();

        // ---- reset state and boot ----
        check_eq("a_rst_pc", pc_a, 64'h0);
        check_eq("a_rst_prev", prev_a, 64'h0);
        check_eq("a_rst_bad", bad_a, 64'h0);
        check_eq("a_rst_mis", 64'(mis_a), 64'h0);
        check_eq("a_rst_fv", 64'(fv_a), 64'h0);
        rst_a = 0;
        check_eq("a_boot_fv", 64'(fv_a), 64'h0);
        step();
        check_eq("a_run_pc", pc_a, 64'h0);
        check_eq("a_run_fv", 64'(fv_a), 64'h1);

        // ---- reset mid-run ----
        branch_taken = 1; branch_target = 64'h40;
        step();
        check_eq("a_br40_pc", pc_a, 64'h40);
        clear_inputs();
        #3 rst_a = 1;
        #1;
        check_eq("a_midrst_pc", pc_a, 64'h0);
        check_eq("a_midrst_fv", 64'(fv_a), 64'h0);
        check_eq("a_midrst_prev", prev_a, 64'h0);
        rst_a = 0;
        step();
        check_eq("a_reboot_pc", pc_a, 64'h0);
        check_eq("a_reboot_fv", 64'(fv_a), 64'h1);
        step();
        check_eq("a_seq4", pc_a, 64'h4);
        step();
        check_eq("a_seq8", pc_a, 64'h8);
        step();
        check_eq("a_seqC", pc_a, 64'hC);
        check_eq("a_seqC_prev", prev_a, 64'h8);
        check_eq("a_seqC_inc", inc_a, 64'h10);

        // ---- stall vs branch ----
        branch_taken = 1; branch_target = 64'h10;
        step();
        check_eq("a_br10_pc", pc_a, 64'h10);
        clear_inputs();
        stall = 1;
        #1;
        check_eq("a_stall_fv", 64'(fv_a), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("a_stall_pc", pc_a, 64'h10);
            check_eq("a_stall_prev", prev_a, 64'hC);
        end
        branch_taken = 1; branch_target = 64'h80;
        step();
        check_eq("a_stallbr_pc", pc_a, 64'h80);
        check_eq("a_stallbr_prev", prev_a, 64'h10);
        clear_inputs();

        // ---- priority ----
        trap = 1; mret = 1; epc_in = 64'h200;
        jalr_taken = 1; jalr_target = 64'h301;
        branch_taken = 1; branch_target = 64'h400;
        step();
        check_eq("a_prio_trap", pc_a, 64'h100);
        check_eq("a_prio_trap_mis", 64'(mis_a), 64'h0);
        trap = 0;
        step();
        check_eq("a_prio_mret", pc_a, 64'h200);
        mret = 0; branch_taken = 0;
        step();
        check_eq("a_jalr_pc", pc_a, 64'h300);
        check_eq("a_jalr_mis", 64'(mis_a), 64'h0);
        clear_inputs();

        // ---- misalignment ----
        branch_taken = 1; branch_target = 64'h82;
        step();
        check_eq("a_mis82_pc", pc_a, 64'h100);
        check_eq("a_mis82_flag", 64'(mis_a), 64'h1);
        check_eq("a_mis82_bad", bad_a, 64'h82);
        clear_inputs();
        step();
        check_eq("a_mis_drop_pc", pc_a, 64'h104);
        check_eq("a_mis_drop_flag", 64'(mis_a), 64'h0);
        check_eq("a_mis_drop_bad", bad_a, 64'h82);
        branch_taken = 1; branch_target = 64'h46;
        step();
        check_eq("a_mis46_flag", 64'(mis_a), 64'h1);
        check_eq("a_mis46_bad", bad_a, 64'h46);
        clear_inputs();
        stall = 1;
        step();
        check_eq("a_mis_stall_flag", 64'(mis_a), 64'h0);
        check_eq("a_mis_stall_pc", pc_a, 64'h100);
        clear_inputs();
        trap = 1; branch_taken = 1; branch_target = 64'h86;
        step();
        check_eq("a_trapmis_pc", pc_a, 64'h100);
        check_eq("a_trapmis_flag", 64'(mis_a), 64'h0);
        check_eq("a_trapmis_bad", bad_a, 64'h46);
        clear_inputs();
        rst_a = 1;

        // ---- ALIGN_BITS=1, redirects during boot ignored ----
        rst_b = 0;
        branch_taken = 1; branch_target = 64'h82;
        step();
        check_eq("b_boot_pc", pc_b, 64'h0);
        check_eq("b_boot_fv", 64'(fv_b), 64'h1);
        step();
        check_eq("b_br82_pc", pc_b, 64'h82);
        check_eq("b_br82_mis", 64'(mis_b), 64'h0);
        check_eq("b_br82_bad", bad_b, 64'h0);
        clear_inputs();
        jalr_taken = 1; jalr_target = 64'h87;
        step();
        check_eq("b_jalr_bit0", pc_b, 64'h86);
        check_eq("b_jalr_mis", 64'(mis_b), 64'h0);
        clear_inputs();
        rst_b = 1;

        // ---- XLEN=32 wrap ----
        rst_c = 0;
        step();
        check_eq("c_boot_pc", 64'(pc_c), 64'h0);
        mret = 1; epc_in = 64'hFFFF_FFFC;
        step();
        check_eq("c_top_pc", 64'(pc_c), 64'hFFFF_FFFC);
        check_eq("c_top_inc", 64'(inc_c), 64'h0);
        clear_inputs();
        step();
        check_eq("c_wrap_pc", 64'(pc_c), 64'h0);
        check_eq("c_wrap_inc", 64'(inc_c), 64'h4);
        check_eq("c_wrap_mis", 64'(mis_c), 64'h0);
        check_eq("c_wrap_prev", 64'(prev_c), 64'hFFFF_FFFC);
        rst_c = 1;

        // ---- XLEN=32, INC=2, RESET_VECTOR=0x1000 ----
        check_eq("d_rst_pc", 64'(pc_d), 64'h1000);
        rst_d = 0;
        step();
        check_eq("d_boot_pc", 64'(pc_d), 64'h1000);
        check_eq("d_boot_fv", 64'(fv_d), 64'h1);
        step();
        check_eq("d_seq1002", 64'(pc_d), 64'h1002);
        step();
        check_eq("d_seq1004", 64'(pc_d), 64'h1004);
        mret = 1; epc_in = 64'h2000;
        step();
        check_eq("d_mret_pc", 64'(pc_d), 64'h2000);
        check_eq("d_mret_inc", 64'(inc_d), 64'h2002);
        clear_inputs();
        rst_d = 1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Parametrised fetch-stage PC register, successor to the fixed 64-bit PC. Adds:
- configurable width, reset vector and increment
- prioritised next-PC selection (trap, mret, jalr, branch, stall, sequential)
- target-misalignment trapping
- a boot state that gates fetch validity after reset

Sits between the branch/jump resolution logic and instruction memory. Feeds the IF/ID pipeline register.

Parameters:
XLEN, 64, PC and target width in bits
RESET_VECTOR, 0, PC value loaded while reset is high
TRAP_VECTOR, 'h100, PC loaded on trap or misaligned redirect
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of low target bits that must be zero (1 when compressed instructions are supported)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold PC; ignored when any redirect is active
branch_taken  input  1  conditional branch resolved taken
branch_target  input  XLEN  branch destination
jalr_taken  input  1  JALR/JAL redirect
jalr_target  input  XLEN  jump destination; bit 0 is forced to 0 before use
trap  input  1  exception/interrupt redirect to TRAP_VECTOR
mret  input  1  return from trap
epc_in  input  XLEN  return address for mret
PC_Out  output  XLEN  current fetch address
PC_Plus_Inc  output  XLEN  PC_Out + INC (combinational, wraps mod 2^XLEN)
PC_Prev  output  XLEN  PC_Out of the previous accepted cycle
fetch_valid  output  1  PC_Out is a valid fetch this cycle
misaligned  output  1  one-cycle pulse: last redirect target was misaligned
bad_addr  output  XLEN  captured misaligned target

Behaviour:
- Reset (async, any time, including mid-redirect):
  - PC_Out=RESET_VECTOR, PC_Prev=RESET_VECTOR, bad_addr=0
  - misaligned=0, fetch_valid=0, state=BOOT
- FSM states BOOT and RUN:
  - BOOT→RUN on the first rising edge with reset low; PC is not updated on that edge.
  - RUN stays in RUN until reset.
- fetch_valid = (state==RUN) & ~stall.
- In RUN, PC updates on each rising edge. Priority, highest first:
  1. trap: PC<=TRAP_VECTOR
  2. mret: PC<=epc_in
  3. jalr_taken: PC<=jalr_target with bit 0 cleared
  4. branch_taken: PC<=branch_target
  5. stall: PC holds
  6. otherwise: PC<=PC+INC
- Misaligned redirect (cases 2–4): if the selected target[ALIGN_BITS-1:0]!=0:
  - PC<=TRAP_VECTOR, bad_addr<=target, misaligned=1 for exactly the next cycle.
  - A simultaneous trap wins: PC<=TRAP_VECTOR, misaligned stays 0, bad_addr unchanged.
- A redirect overrides stall. Stall never blocks trap or mret.
- PC_Prev<=PC_Out on every edge where PC_Out changes. It holds during stall.
- Arithmetic: XLEN-bit unsigned, modulo 2^XLEN. Increment at 2^XLEN-INC wraps to 0 with no flag.
- Redirect inputs asserted in BOOT are ignored.
- misaligned deasserts after one cycle even if stall is high.

Decomposition:
- Shared package/include (riscv_defs) holds XLEN default, RESET_VECTOR, TRAP_VECTOR and the PC-select encoding: SEL_TRAP, SEL_MRET, SEL_JALR, SEL_BR, SEL_HOLD, SEL_SEQ.
- One combinational sub-module, next_pc_select, computes the select code, selected target and misalignment flag.
- program_counter_unit holds the registers and the FSM.

Test Plan:
1. Reset mid-run: PC=0x40, assert reset between edges → PC_Out=0 immediately, fetch_valid=0. Release reset → one BOOT cycle, then PC 0,4,8,0xC on successive edges, with fetch_valid=1 from the RUN cycle on.
2. Stall vs branch: stall=1 for 3 edges at PC=0x10 → PC holds 0x10, PC_Prev holds, fetch_valid=0. Then stall=1 with branch_taken=1, target 0x80 → PC=0x80 next edge.
3. Priority: trap, mret (epc 0x200), jalr (0x301) and branch (0x400) asserted together → PC=0x100. Repeat without trap → PC=0x200. Then jalr alone with 0x301 → PC=0x300, misaligned=0.
4. Misalignment: branch_target=0x82, ALIGN_BITS=2 → PC=0x100, misaligned=1 for one cycle, bad_addr=0x82. Same target with ALIGN_BITS=1 → PC=0x82, no flag.
5. Wrap-around, XLEN=32: PC=0xFFFFFFFC, no redirect → PC=0x00000000, PC_Plus_Inc=0x4, no flag.
6. Parameter sweep: XLEN=32, INC=2, RESET_VECTOR=0x1000 → after reset PC sequence 0x1000,0x1002,0x1004; mret to epc 0x2000 → 0x2000.
